// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sprite_rom_arbiter                                         |
// | Description : Round-robin sharing of one sprite ROM read port between    |
// |               two sprite renderers (player 0, player 1). Each accepted   |
// |               request carries its requester tag through a pipeline that  |
// |               matches the ROM latency, so the response returns to the    |
// |               requester that issued it. Out-of-range addresses are       |
// |               answered with TRANSP_RGB and the ROM sees address 0.       |
// | Ports       : clk, rst_n          clock, async active-low reset          |
// |               pN_req_valid/addr  request from player N (N = 0, 1)        |
// |               pN_req_ready       grant to player N this cycle            |
// |               pN_rsp_valid/rgb/oob  one-cycle response to player N       |
// |               rom_addr / rom_rgb    shared ROM read port                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sprite_rom_arbiter #(
    parameter int         SPRITE_DEPTH = 1200,
    parameter int         ROM_LAT      = 0,
    parameter logic [5:0] TRANSP_RGB   = 6'b110011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req_valid,
    input  logic [13:0] p0_req_addr,
    output logic        p0_req_ready,
    output logic        p0_rsp_valid,
    output logic [5:0]  p0_rsp_rgb,
    output logic        p0_rsp_oob,
    input  logic        p1_req_valid,
    input  logic [13:0] p1_req_addr,
    output logic        p1_req_ready,
    output logic        p1_rsp_valid,
    output logic [5:0]  p1_rsp_rgb,
    output logic        p1_rsp_oob,
    output logic [13:0] rom_addr,
    input  logic [5:0]  rom_rgb
);

    localparam logic [13:0] c_depth = 14'(SPRITE_DEPTH);

    logic        r_last_grant;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_hs;
    logic [13:0] w_addr;
    logic        w_in_range;

    // Stage at which rom_rgb is valid for the request it belongs to.
    logic        w_smp_valid;
    logic        w_smp_tag;
    logic        w_smp_oob;

    // A tie goes to whichever requester was not served last.
    assign w_grant0 = p0_req_valid & (~p1_req_valid | r_last_grant);
    assign w_grant1 = p1_req_valid & (~p0_req_valid | ~r_last_grant);

    assign p0_req_ready = w_grant0;
    assign p1_req_ready = w_grant1;

    // A grant implies the matching valid, so any grant is a handshake.
    assign w_hs       = w_grant0 | w_grant1;
    assign w_addr     = w_grant1 ? p1_req_addr : p0_req_addr;
    assign w_in_range = (w_addr < c_depth);

    // The ROM never sees an out-of-range address.
    assign rom_addr = (w_hs && w_in_range) ? w_addr : 14'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_hs) begin
            r_last_grant <= w_grant1;
        end
    end

    generate
        if (ROM_LAT == 0) begin : g_lat0
            // Combinational ROM: data belongs to the request granted now.
            assign w_smp_valid = w_hs;
            assign w_smp_tag   = w_grant1;
            assign w_smp_oob   = ~w_in_range;
        end else begin : g_lat1
            logic r_valid;
            logic r_tag;
            logic r_oob;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_tag   <= 1'b0;
                    r_oob   <= 1'b0;
                end else begin
                    r_valid <= w_hs;
                    r_tag   <= w_grant1;
                    r_oob   <= ~w_in_range;
                end
            end

            assign w_smp_valid = r_valid;
            assign w_smp_tag   = r_tag;
            assign w_smp_oob   = r_oob;
        end
    endgenerate

    // Response registers: only the tagged side updates colour/oob; the
    // other side keeps its previous values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rsp_valid <= 1'b0;
            p0_rsp_rgb   <= 6'b000000;
            p0_rsp_oob   <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_rgb   <= 6'b000000;
            p1_rsp_oob   <= 1'b0;
        end else begin
            p0_rsp_valid <= w_smp_valid & ~w_smp_tag;
            p1_rsp_valid <= w_smp_valid &  w_smp_tag;
            if (w_smp_valid && !w_smp_tag) begin
                p0_rsp_rgb <= w_smp_oob ? TRANSP_RGB : rom_rgb;
                p0_rsp_oob <= w_smp_oob;
            end
            if (w_smp_valid && w_smp_tag) begin
                p1_rsp_rgb <= w_smp_oob ? TRANSP_RGB : rom_rgb;
                p1_rsp_oob <= w_smp_oob;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one sprite ROM read port (14-bit address in, 6-bit palette-resolved RGB out) between two requesters, player 0 and player 1 sprite renderers. Each requester has a valid/ready request channel and a valid-only response channel. Arbitration is round-robin, with per-requester in-flight tagging through a ROM-latency pipeline. Out-of-range addresses are answered with the transparent key colour without consulting the ROM.

Parameters:
SPRITE_DEPTH, 1200, number of valid ROM entries; addresses >= this are out of range.
ROM_LAT, 0, ROM read latency in cycles: 0 = combinational ROM, 1 = registered ROM. Only 0 and 1 are supported.
TRANSP_RGB, 6'b110011, colour returned for out-of-range requests.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
p0_req_valid  in  1  player 0 requests a read
p0_req_addr  in  14  player 0 read address
p0_req_ready  out  1  player 0 request accepted this cycle
p0_rsp_valid  out  1  player 0 response strobe, one cycle
p0_rsp_rgb  out  6  player 0 response colour
p0_rsp_oob  out  1  player 0 response was out of range
p1_req_valid  in  1  player 1 requests a read
p1_req_addr  in  14  player 1 read address
p1_req_ready  out  1  player 1 request accepted this cycle
p1_rsp_valid  out  1  player 1 response strobe
p1_rsp_rgb  out  6  player 1 response colour
p1_rsp_oob  out  1  player 1 response was out of range
rom_addr  out  14  address to the sprite ROM
rom_rgb  in  6  ROM colour, ROM_LAT cycles after rom_addr

Behaviour:
- Reset (async, rst_n=0): last_grant=1, so p0 wins the first tie. Pipeline valid bits, all rsp_valid and rsp_oob are 0, all rsp_rgb are 6'b000000.
- Arbitration is combinational in the current cycle. At most one grant per cycle.
  - Only one requester valid: it is granted.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant. last_grant holds.
- pN_req_ready = grant_N. A handshake is pN_req_valid & pN_req_ready. A requester may change its address only after its handshake.
- On a handshake, last_grant updates to the granted index at the next edge.
- rom_addr = the granted address when a grant is in range, otherwise 14'd0. Never out of range.
- In range means addr < SPRITE_DEPTH, compared at 14 bits. addr = SPRITE_DEPTH-1 is in range; addr = SPRITE_DEPTH is out of range.
- Pipeline: a shift register of depth ROM_LAT+1 carries {valid, tag, oob} for each accepted request.
  - ROM_LAT=0: rom_rgb is sampled in the grant cycle. The response is registered and appears exactly 1 cycle after the handshake.
  - ROM_LAT=1: rom_rgb is sampled 1 cycle after the grant. The response appears exactly 2 cycles after the handshake.
- Response routing: rsp_valid is asserted for exactly one cycle on the tagged requester only.
  - rsp_rgb = rom_rgb if in range, else TRANSP_RGB.
  - rsp_oob = the oob bit.
  - The non-tagged requester's rsp_valid=0 and its rsp_rgb/oob hold their last values.
- Throughput: one accepted request per cycle in total, fully pipelined with no bubbles. Back-to-back grants to alternating requesters are allowed.
- Fairness: with both requesters continuously valid, grants strictly alternate. Neither waits more than 1 cycle.
- Reset mid-operation: in-flight pipeline entries are discarded and no response is emitted for them. Requesters must reissue.
- No response backpressure exists. Requesters must always accept responses.

Test Plan:
- Reset release with both idle -> all rsp_valid=0, both ready=0, rom_addr=0. Then p0 valid, addr 5, rom_rgb=6'b111010 (ROM_LAT=0) -> p0_req_ready=1 that cycle, rom_addr=5; next cycle p0_rsp_valid=1, rgb=6'b111010, oob=0; p1_rsp_valid=0.
- Both valid continuously for 6 cycles, p0 addr 10, p1 addr 20 -> grant order p0,p1,p0,p1,p0,p1. rom_addr sequence 10,20,10,20,10,20. Each response arrives on the correct requester 1 cycle later.
- Boundary addresses: p1 addr 1199 then 1200 then 16383 -> first response uses rom_rgb with oob=0. Second and third give rgb=6'b110011, oob=1, and rom_addr=0 in their grant cycles.
- ROM_LAT=1 with a ROM model delaying 1 cycle, alternating streams -> every response lags its handshake by exactly 2 cycles, data matches the per-address model, no drops or duplicates over 200 random requests.
- p0 valid alone for 4 cycles after a p1 grant -> p0 granted all 4 cycles (no idle gaps). Then both valid -> p1 wins (last_grant=0).
- Assert rst_n low for 1 cycle with 2 requests in flight (ROM_LAT=1) -> all rsp_valid drop immediately, no stale responses after release, and the first tie after release goes to p0.
